// File: rtl/wb_btn_led_pkg.sv
// Shared constants for the Wishbone button/LED controller.
// Register offsets, field widths and CTRL bit positions.
package wb_btn_led_pkg;

  localparam int NBTN  = 3;
  localparam int LED_W = 8;
  localparam int CNT_W = 16;

  localparam logic [1:0] REG_LED   = 2'd0;
  localparam logic [1:0] REG_STATE = 2'd1;
  localparam logic [1:0] REG_EVENT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_AUTO_BIT = 0;
  localparam int CTRL_MASK_LSB = 4;
  localparam int CTRL_MASK_W   = 3;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, rise pulse.
// rise_o pulses in the same cycle deb_o first reads 1.
module btn_debounce
  import wb_btn_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic deb_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             deb_q, deb_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    deb_d  = deb_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d  = sync_q[1];
        rise_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/wb_btn_led_ctrl.sv
// Wishbone LED register, debounced buttons, W1C events, AUTO mode.
// Optional BTN_IRQ_EN adds irq_o and IRQ_MASK at CTRL[6:4].
module wb_btn_led_ctrl
  import wb_btn_led_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [2:0]  btn_i,
  output logic [7:0]  led_o,
  output logic [7:0]  led_oeb_o
`ifdef BTN_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic [NBTN-1:0]  deb, rise;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [NBTN-1:0]  ev_q, ev_d;
  logic             auto_q, auto_d;
  logic [CTRL_MASK_W-1:0] mask;
  logic [31:0]      rdata;
  logic             req, wr;
  logic [1:0]       off;
  logic             unused;

  for (genvar k = 0; k < NBTN; k++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rst_ni),
      .btn_i (btn_i[k]),
      .deb_o (deb[k]),
      .rise_o(rise[k])
    );
  end

  assign req = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off = wbs_adr_i[3:2];
  assign ack_d = req & ~ack_q;
  assign wr = ack_d & wbs_we_i & wbs_sel_i[0];

`ifdef BTN_IRQ_EN
  logic [CTRL_MASK_W-1:0] mask_q, mask_d;
  logic                   irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr && off == REG_CTRL)
      mask_d = wbs_dat_i[CTRL_MASK_LSB +: CTRL_MASK_W];
    irq_d = |(ev_q & mask_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask  = mask_q;
  assign irq_o = irq_q;
`else
  assign mask = '0;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == REG_LED:   rdata[LED_W-1:0] = led_q;
      off == REG_STATE: rdata[NBTN-1:0]  = deb;
      off == REG_EVENT: rdata[NBTN-1:0]  = ev_q;
      off == REG_CTRL: begin
        rdata[CTRL_AUTO_BIT] = auto_q;
        rdata[CTRL_MASK_LSB +: CTRL_MASK_W] = mask;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    dat_d  = ack_d ? rdata : '0;
    auto_d = auto_q;
    ev_d   = ev_q;
    led_d  = led_q;
    if (wr && off == REG_CTRL)
      auto_d = wbs_dat_i[CTRL_AUTO_BIT];
    // Clear first so a same-cycle rise wins.
    if (wr && off == REG_EVENT)
      ev_d = ev_q & ~wbs_dat_i[NBTN-1:0];
    ev_d = ev_d | rise;
    if (wr && off == REG_LED) begin
      led_d = wbs_dat_i[LED_W-1:0];
    end else if (auto_q) begin
      if (rise[2])      led_d = 8'hFF;
      else if (rise[1]) led_d = 8'h00;
      else if (rise[0]) led_d = led_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      led_q  <= '0;
      ev_q   <= '0;
      auto_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      led_q  <= led_d;
      ev_q   <= ev_d;
      auto_q <= auto_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign led_o     = led_q;
  assign led_oeb_o = 8'h00;
  assign unused    = ^{wbs_dat_i[31:8], wbs_sel_i[3:1],
                       wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_btn_led_ctrl.sv
// Scoreboard bench: driver queues expected responses,
// a negedge monitor pops and checks them on every ack.
module tb_wb_btn_led_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  btn = 3'b000;
  logic [7:0]  led, oeb;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   prev_ack = 1'b0;

  wb_btn_led_ctrl #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .btn_i    (btn),
    .led_o    (led),
    .led_oeb_o(oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got ack=1 want ack=0 adr=%h",
                   adr);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.rd && rdat !== e.data) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, rdat, e.data);
          end
        end
        if (prev_ack) begin
          total++;
          bad++;
          $display("FAIL ack_width: got 2+ cycles want 1");
        end
      end else begin
        total++;
        if (rdat !== 32'h0) begin
          bad++;
          $display("FAIL dat_idle: got %h want 0", rdat);
        end
      end
      prev_ack = ack;
    end
  end

  task automatic xfer(input string nm, input bit w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit exp_ack,
                      input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    bit   got;
    e.rd = ~w;
    e.data = exp_rd;
    e.name = nm;
    if (exp_ack) q.push_back(e);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = d; sel = s;
    got = 1'b0;
    n = 0;
    while (!got && n < 16) begin
      @(posedge clk);
      #1;
      n++;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (exp_ack) begin
      chk({nm, "_latency"}, got ? n : 99, 1);
    end else begin
      chk({nm, "_noack"}, {31'b0, got}, 0);
    end
  endtask

  task automatic rd(input string nm, input logic [3:0] o,
                    input logic [31:0] exp);
    xfer(nm, 1'b0, BASE + o, '0, 4'hF, 1'b1, exp);
  endtask

  task automatic wr(input string nm, input logic [3:0] o,
                    input logic [31:0] d);
    xfer(nm, 1'b1, BASE + o, d, 4'hF, 1'b1, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_led", {24'b0, led}, 0);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("oeb", {24'b0, oeb}, 0);
    rd("rst_state", 4'h4, 0);
    rd("rst_event", 4'h8, 0);
    rd("rst_ctrl", 4'hC, 0);

    wr("wr_led", 4'h0, 32'h0000_00A5);
    chk("led_a5", {24'b0, led}, 32'hA5);
    rd("rd_led", 4'h0, 32'h0000_00A5);

    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat (5) @(posedge clk);
          #1 btn[0] = ~btn[0];
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          repeat (14) @(posedge clk);
          rd("bounce_state", 4'h4, 0);
        end
      end
    join
    @(posedge clk);
    #1 btn[0] = 1'b1;
    repeat (8) @(posedge clk);
    rd("early_state", 4'h4, 0);
    repeat (20) @(posedge clk);
    rd("stable_state", 4'h4, 1);
    rd("stable_event", 4'h8, 1);
    wr("w1c_all", 4'h8, 7);
    rd("event_clr", 4'h8, 0);

    wr("auto_on", 4'hC, 1);
    wr("led_ff", 4'h0, 32'hFF);
    #1 btn[0] = 1'b0;
    repeat (25) @(posedge clk);
    chk("auto_fall", {24'b0, led}, 32'hFF);
    #1 btn[0] = 1'b1;
    repeat (25) @(posedge clk);
    chk("auto_wrap", {24'b0, led}, 32'h00);
    rd("auto_ev0", 4'h8, 1);
    #1 btn = 3'b111;
    repeat (25) @(posedge clk);
    chk("auto_prio", {24'b0, led}, 32'hFF);
    rd("state_111", 4'h4, 7);
    rd("event_111", 4'h8, 7);

    wr("ctrl_71", 4'hC, 32'h71);
`ifdef BTN_IRQ_EN
    rd("ctrl_rd", 4'hC, 32'h71);
`else
    rd("ctrl_rd", 4'hC, 32'h01);
`endif
    wr("auto_off", 4'hC, 0);
    #1 btn = 3'b000;
    repeat (25) @(posedge clk);
    wr("w1c_7", 4'h8, 7);
    rd("ev_zero", 4'h8, 0);

    btn[0] = 1'b1;
    repeat (17) @(posedge clk);
    wr("w1c_race", 4'h8, 1);
    rd("ev_race", 4'h8, 1);
    rd("st_race", 4'h4, 1);

    xfer("sel0_off", 1'b1, BASE, 32'h3C, 4'hE, 1'b1, '0);
    rd("sel_led", 4'h0, 32'hFF);

    xfer("oob_wr", 1'b1, BASE + 32'h10, 32'h12, 4'hF, 1'b0, '0);
    chk("oob_led", {24'b0, led}, 32'hFF);
    rd("oob_rd_led", 4'h0, 32'hFF);
    xfer("oob_rd", 1'b0, BASE + 32'h14, '0, 4'hF, 1'b0, '0);

    repeat (4) @(posedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
